// File: rtl/modn_wrap_monitor.sv
// Wrap/step monitor for a loadable mod-N counter with a 2-deep valid/ready event queue.
// Optional feature: define MODN_WRAP_MON_TIMESTAMP_EN to add evt_time and a free-running cycle stamp.

module modn_wrap_monitor #(
   parameter int unsigned N     = 6,
   parameter int unsigned WIDTH = 3,
   parameter int unsigned CW    = 8,
   parameter int unsigned TSW   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] q,
   output logic             wrap_pulse,
   output logic [CW-1:0]    wrap_count,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [1:0]       evt_type,
   output logic [WIDTH-1:0] evt_value,
`ifdef MODN_WRAP_MON_TIMESTAMP_EN
   output logic [TSW-1:0]   evt_time,
`endif
   output logic             overflow_err
);

   localparam logic [WIDTH-1:0] LAST_Q       = WIDTH'(N - 1);
   localparam logic [WIDTH:0]   N_EXT        = (WIDTH + 1)'(N);
   localparam logic [1:0]       KIND_NONE    = 2'b00;
   localparam logic [1:0]       KIND_LOAD    = 2'b01;
   localparam logic [1:0]       KIND_ILLEGAL = 2'b10;

   if ((2 ** WIDTH) < N || TSW == 0) begin : g_bad_cfg
      $error("modn_wrap_monitor: parameters need 2**WIDTH >= N and TSW > 0");
   end

   typedef struct packed {
      logic [1:0]       kind;
      logic [WIDTH-1:0] value;
`ifdef MODN_WRAP_MON_TIMESTAMP_EN
      logic [TSW-1:0]   stamp;
`endif
   } entry_t;

   logic [WIDTH-1:0] q_prev_reg;
   logic             load_d_reg;
   logic             prev_ok_reg;
   logic             wrap_pulse_reg;
   logic [CW-1:0]    wrap_count_reg;
   entry_t           head_reg;
   entry_t           head_next;
   entry_t           tail_reg;
   entry_t           tail_next;
   logic [1:0]       count_reg;
   logic [1:0]       count_next;
   logic             ovf_reg;
   logic             ovf_next;

   logic [WIDTH-1:0] q_inc;
   logic             q_high;
   logic             push;
   logic             is_wrap;
   logic [1:0]       new_kind;
   entry_t           new_entry;
   logic             pop;

`ifdef MODN_WRAP_MON_TIMESTAMP_EN
   logic [TSW-1:0]   stamp_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         stamp_reg <= '0;
      end else begin
         stamp_reg <= stamp_reg + 1'b1;
      end
   end
`endif

   // Classify the current sample against the previous one; first matching rule wins.
   always_comb begin
      q_inc    = q_prev_reg + 1'b1;
      q_high   = ({1'b0, q} >= N_EXT);
      push     = 1'b0;
      is_wrap  = 1'b0;
      new_kind = KIND_NONE;
      if (prev_ok_reg) begin
         if (load_d_reg) begin
            push     = 1'b1;
            new_kind = KIND_LOAD;
         end else if (q_high) begin
            push     = 1'b1;
            new_kind = KIND_ILLEGAL;
         end else if (q_prev_reg == LAST_Q && q == '0) begin
            is_wrap = 1'b1;
         end else if (q == q_inc && q_prev_reg < LAST_Q) begin
            push = 1'b0;
         end else begin
            push     = 1'b1;
            new_kind = KIND_ILLEGAL;
         end
      end
   end

   always_comb begin
      new_entry       = '0;
      new_entry.kind  = new_kind;
      new_entry.value = q;
`ifdef MODN_WRAP_MON_TIMESTAMP_EN
      new_entry.stamp = stamp_reg;
`endif
   end

   assign pop = evt_valid & evt_ready;

   // Head/tail queue: the head register feeds the outputs directly, so a pop shifts tail into head.
   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      ovf_next   = ovf_reg;
      case (count_reg)
         2'd0: begin
            if (push) begin
               head_next  = new_entry;
               count_next = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               head_next = new_entry;
            end else if (push) begin
               tail_next  = new_entry;
               count_next = 2'd2;
            end else if (pop) begin
               count_next = 2'd0;
            end
         end
         default: begin
            if (pop) begin
               head_next = tail_reg;
               if (push) begin
                  tail_next = new_entry;
               end else begin
                  count_next = 2'd1;
               end
            end else if (push) begin
               ovf_next = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_prev_reg     <= '0;
         load_d_reg     <= 1'b0;
         prev_ok_reg    <= 1'b0;
         wrap_pulse_reg <= 1'b0;
         wrap_count_reg <= '0;
         head_reg       <= '0;
         tail_reg       <= '0;
         count_reg      <= 2'd0;
         ovf_reg        <= 1'b0;
      end else begin
         q_prev_reg     <= q;
         load_d_reg     <= load;
         prev_ok_reg    <= 1'b1;
         wrap_pulse_reg <= is_wrap;
         if (is_wrap) begin
            wrap_count_reg <= wrap_count_reg + 1'b1;
         end
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
         ovf_reg   <= ovf_next;
      end
   end

   assign wrap_pulse   = wrap_pulse_reg;
   assign wrap_count   = wrap_count_reg;
   assign evt_valid    = (count_reg != 2'd0);
   assign evt_type     = head_reg.kind;
   assign evt_value    = head_reg.value;
   assign overflow_err = ovf_reg;
`ifdef MODN_WRAP_MON_TIMESTAMP_EN
   assign evt_time     = head_reg.stamp;
`endif

endmodule

// File: tb/tb_modn_wrap_monitor.sv
// Self-checking bench for modn_wrap_monitor: directed vector table, hand sequences
// for reset/rollover corners, and random stimulus against a queue-based reference model.

module tb_modn_wrap_monitor;

   localparam int N   = 6;
   localparam int W   = 3;
   localparam int CW  = 8;
   localparam int TSW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load = 1'b0;
   logic [W-1:0]  q = '0;
   logic          evt_ready = 1'b0;
   logic          wrap_pulse;
   logic [CW-1:0] wrap_count;
   logic          evt_valid;
   logic [1:0]    evt_type;
   logic [W-1:0]  evt_value;
   logic          overflow_err;
`ifdef MODN_WRAP_MON_TIMESTAMP_EN
   logic [TSW-1:0] evt_time;
`endif

   modn_wrap_monitor #(.N(N), .WIDTH(W), .CW(CW), .TSW(TSW)) dut (
      .clk          (clk),
      .rst          (rst),
      .load         (load),
      .q            (q),
      .wrap_pulse   (wrap_pulse),
      .wrap_count   (wrap_count),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_type     (evt_type),
      .evt_value    (evt_value),
`ifdef MODN_WRAP_MON_TIMESTAMP_EN
      .evt_time     (evt_time),
`endif
      .overflow_err (overflow_err)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model: event list as a queue, counts as plain integers.
   typedef struct {
      int kind;
      int value;
      int stamp;
   } mevt_t;

   mevt_t m_q[$];
   int    m_prev    = 0;
   bit    m_load_d  = 0;
   bit    m_prev_ok = 0;
   bit    m_pulse   = 0;
   int    m_wraps   = 0;
   bit    m_ovf     = 0;
   int    m_ts      = 0;

   task automatic model_edge(input bit l, input int qq, input bit r, input bit rs);
      mevt_t e;
      bit    has_evt;
      has_evt = 0;
      e.kind  = 0;
      e.value = qq;
      e.stamp = m_ts;
      if (rs) begin
         m_q.delete();
         m_prev    = 0;
         m_load_d  = 0;
         m_prev_ok = 0;
         m_pulse   = 0;
         m_wraps   = 0;
         m_ovf     = 0;
         m_ts      = 0;
         return;
      end
      m_pulse = 0;
      if (m_prev_ok) begin
         if (m_load_d) begin
            has_evt = 1; e.kind = 1;
         end else if (qq >= N) begin
            has_evt = 1; e.kind = 2;
         end else if (m_prev == N - 1 && qq == 0) begin
            m_pulse = 1;
            m_wraps = (m_wraps + 1) % (1 << CW);
         end else if (qq != m_prev + 1) begin
            has_evt = 1; e.kind = 2;
         end
      end
      if (m_q.size() > 0 && r) begin
         $display("t=%0t pop kind=%0d value=%0d stamp=%0d", $time, m_q[0].kind, m_q[0].value, m_q[0].stamp);
         void'(m_q.pop_front());
      end
      if (has_evt) begin
         if (m_q.size() < 2) m_q.push_back(e);
         else m_ovf = 1;
      end
      m_prev    = qq;
      m_load_d  = l;
      m_prev_ok = 1;
      m_ts      = (m_ts + 1) % (1 << TSW);
   endtask

   task automatic step(input bit l, input int qq, input bit r, input bit rs);
      logic [31:0] qv;
      qv        = qq;
      load      = l;
      q         = qv[W-1:0];
      evt_ready = r;
      rst       = rs;
      @(posedge clk);
      model_edge(l, qq, r, rs);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cmp_model(input string tag);
      chk({tag, " wrap_pulse"}, 32'(wrap_pulse), 32'(m_pulse));
      chk({tag, " wrap_count"}, 32'(wrap_count), m_wraps);
      chk({tag, " evt_valid"}, 32'(evt_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
         chk({tag, " evt_type"}, 32'(evt_type), m_q[0].kind);
         chk({tag, " evt_value"}, 32'(evt_value), m_q[0].value);
`ifdef MODN_WRAP_MON_TIMESTAMP_EN
         chk({tag, " evt_time"}, 32'(evt_time), m_q[0].stamp);
`endif
      end
      chk({tag, " overflow_err"}, 32'(overflow_err), 32'(m_ovf));
   endtask

   typedef struct {
      bit load;
      int q;
      bit rdy;
      bit pulse;
      int cnt;
      bit valid;
      int kind;
      int value;
      bit ovf;
   } vec_t;

   vec_t tbl[18];

   initial begin
      int cur;
      bit ld_prev;
      bit ld;
      bit rs;
      int rsel;

      // load, q, rdy | pulse, count, valid, type, value, ovf
      tbl[0]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{0, 2, 1, 0, 0, 0, 0, 0, 0};
      tbl[3]  = '{0, 3, 1, 0, 0, 0, 0, 0, 0};
      tbl[4]  = '{0, 4, 1, 0, 0, 0, 0, 0, 0};
      tbl[5]  = '{0, 5, 1, 0, 0, 0, 0, 0, 0};
      tbl[6]  = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
      tbl[7]  = '{0, 1, 1, 0, 1, 0, 0, 0, 0};
      tbl[8]  = '{1, 2, 1, 0, 1, 0, 0, 0, 0};
      tbl[9]  = '{0, 4, 1, 0, 1, 1, 1, 4, 0};
      tbl[10] = '{0, 5, 1, 0, 1, 0, 0, 0, 0};
      tbl[11] = '{0, 5, 0, 0, 1, 1, 2, 5, 0};
      tbl[12] = '{0, 7, 0, 0, 1, 1, 2, 5, 0};
      tbl[13] = '{0, 3, 1, 0, 1, 1, 2, 7, 0};
      tbl[14] = '{0, 3, 0, 0, 1, 1, 2, 7, 1};
      tbl[15] = '{0, 4, 1, 0, 1, 1, 2, 3, 1};
      tbl[16] = '{0, 5, 1, 0, 1, 0, 0, 0, 1};
      tbl[17] = '{0, 0, 1, 1, 2, 0, 0, 0, 1};

      step(0, 0, 1, 1);
      chk("reset wrap_pulse", 32'(wrap_pulse), 0);
      chk("reset wrap_count", 32'(wrap_count), 0);
      chk("reset evt_valid", 32'(evt_valid), 0);
      chk("reset evt_type", 32'(evt_type), 0);
      chk("reset evt_value", 32'(evt_value), 0);
      chk("reset overflow_err", 32'(overflow_err), 0);

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].load, tbl[i].q, tbl[i].rdy, 0);
         chk($sformatf("row%0d wrap_pulse", i), 32'(wrap_pulse), 32'(tbl[i].pulse));
         chk($sformatf("row%0d wrap_count", i), 32'(wrap_count), tbl[i].cnt);
         chk($sformatf("row%0d evt_valid", i), 32'(evt_valid), 32'(tbl[i].valid));
         if (tbl[i].valid) begin
            chk($sformatf("row%0d evt_type", i), 32'(evt_type), tbl[i].kind);
            chk($sformatf("row%0d evt_value", i), 32'(evt_value), tbl[i].value);
         end
         chk($sformatf("row%0d overflow_err", i), 32'(overflow_err), 32'(tbl[i].ovf));
      end

      // Reset with two events pending, then an unclassified first sample.
      step(0, 7, 0, 0);
      step(0, 7, 0, 0);
      chk("pending evt_valid", 32'(evt_valid), 1);
      step(0, 3, 0, 1);
      chk("midrst evt_valid", 32'(evt_valid), 0);
      chk("midrst wrap_count", 32'(wrap_count), 0);
      chk("midrst overflow_err", 32'(overflow_err), 0);
      step(0, 3, 1, 0);
      chk("post-rst first sample evt_valid", 32'(evt_valid), 0);
      step(0, 4, 1, 0);
      chk("post-rst step evt_valid", 32'(evt_valid), 0);

      // 256 clean wraps: wrap_count rolls 255 -> 0.
      step(0, 0, 1, 1);
      step(0, 0, 1, 0);
      for (int w = 1; w <= 256; w++) begin
         for (int k = 1; k < N; k++) begin
            step(0, k, 1, 0);
            cmp_model("roll");
         end
         step(0, 0, 1, 0);
         cmp_model("roll");
         if (w == 255) chk("roll count 255", 32'(wrap_count), 255);
      end
      chk("roll count wrapped", 32'(wrap_count), 0);
      chk("roll last pulse", 32'(wrap_pulse), 1);

`ifdef MODN_WRAP_MON_TIMESTAMP_EN
      step(0, 0, 1, 1);
      for (int k = 0; k <= 10; k++) step(k == 10, k % N, 0, 0);
      step(0, 2, 0, 0);
      chk("stamp evt_type", 32'(evt_type), 1);
      chk("stamp evt_value", 32'(evt_value), 2);
      chk("stamp evt_time", 32'(evt_time), 11);
`endif

      // Random counter-like traffic with loads, glitches, resets and a random sink.
      step(0, 0, 1, 1);
      cur     = 0;
      ld_prev = 0;
      for (int i = 0; i < 1500; i++) begin
         rsel = int'($urandom_range(0, 99));
         if (ld_prev) cur = int'($urandom_range(0, N - 1));
         else if (rsel < 80) cur = (cur + 1) % N;
         else if (rsel >= 88) cur = int'($urandom_range(0, 7));
         ld = ($urandom_range(0, 9) == 0);
         rs = ($urandom_range(0, 199) == 0);
         step(ld, cur, 1'($urandom_range(0, 1)), rs);
         cmp_model("rand");
         ld_prev = ld && !rs;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
